ram_access_ctrl: RTL and testbench

//  Sequences and shares one single-port, registered-read side-info RAM (intra4x4_pred_mode,
//  ref_idx, mvp) between two requesters, A (parser write-back) and B (prediction lookup).

---
 rtl/ram_access_ctrl_pkg.sv | 18 +
 rtl/ram_access_ctrl_rr_arb2.sv | 50 +++++
 rtl/ram_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and defaults for the side-info RAM access controller.
// Holds the controller state encoding and the read-issue helper.
package ram_access_ctrl_pkg;

  localparam int ADDR_BITS_DEF = 8;
  localparam int DATA_BITS_DEF = 16;

  typedef enum logic [0:0] {
    CTRL_IDLE  = 1'b0,
    CTRL_CLEAR = 1'b1
  } ctrl_state_e;

  // A granted access with we low is a read whose data returns next cycle.
  function automatic logic read_issued(input logic gnt, input logic we);
    return gnt & ~we;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
// The pointer names the side favoured on the next contended cycle.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: a lone request wins, contention goes to the favoured side.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Pointer moves to the other side after every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset favours A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Shares one registered-read side-info RAM between the parser (A) and the
// prediction lookup (B), and runs a full-depth zeroing sweep at picture start.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_start,
  output logic                 clr_busy,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 ram_wr_n,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_data_in,
  input  logic [DATA_BITS-1:0] ram_data_out
);

  localparam logic [ADDR_BITS-1:0] CNT_LAST = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] CNT_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  ctrl_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                 clr_busy_q, clr_busy_d;
  logic                 a_rvalid_q, a_rvalid_d;
  logic                 b_rvalid_q, b_rvalid_d;

  logic                 arb_en_s;
  logic [1:0]           arb_req_s;
  logic [1:0]           arb_gnt_s;

  // Gating with rst_n keeps grants off while reset is held even if requests are up.
  assign arb_en_s  = rst_n & (state_q == CTRL_IDLE) & ~clr_start;
  assign arb_req_s = {b_req, a_req};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en_s),
    .req   (arb_req_s),
    .gnt   (arb_gnt_s)
  );

  assign a_gnt    = arb_gnt_s[0];
  assign b_gnt    = arb_gnt_s[1];
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign clr_busy = clr_busy_q;
  assign rdata    = ram_data_out;

  // Clear sequencer next state: one word per cycle, back to idle after the last address.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_d = clr_busy_q;
    case (state_q)
      CTRL_IDLE: begin
        if (clr_start) begin
          state_d    = CTRL_CLEAR;
          cnt_d      = {ADDR_BITS{1'b0}};
          clr_busy_d = 1'b1;
        end else begin
          state_d    = CTRL_IDLE;
          clr_busy_d = 1'b0;
        end
      end
      CTRL_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = CTRL_IDLE;
          cnt_d      = {ADDR_BITS{1'b0}};
          clr_busy_d = 1'b0;
        end else begin
          cnt_d      = cnt_q + CNT_ONE;
          clr_busy_d = 1'b1;
        end
      end
      default: begin
        state_d    = CTRL_IDLE;
        cnt_d      = {ADDR_BITS{1'b0}};
        clr_busy_d = 1'b0;
      end
    endcase
  end

  // RAM port mux: the sweep owns the port while clearing, else the granted requester.
  always_comb begin
    ram_wr_n    = 1'b1;
    ram_addr    = {ADDR_BITS{1'b0}};
    ram_data_in = {DATA_BITS{1'b0}};
    if (state_q == CTRL_CLEAR) begin
      ram_wr_n    = 1'b0;
      ram_addr    = cnt_q;
      ram_data_in = {DATA_BITS{1'b0}};
    end else if (arb_gnt_s[0]) begin
      ram_wr_n    = ~a_we;
      ram_addr    = a_addr;
      ram_data_in = a_wdata;
    end else if (arb_gnt_s[1]) begin
      ram_wr_n    = ~b_we;
      ram_addr    = b_addr;
      ram_data_in = b_wdata;
    end else begin
      ram_wr_n    = 1'b1;
      ram_addr    = {ADDR_BITS{1'b0}};
      ram_data_in = {DATA_BITS{1'b0}};
    end
  end

  // The RAM registers its read, so each rvalid trails its read grant by one cycle.
  always_comb begin
    a_rvalid_d = read_issued(arb_gnt_s[0], a_we);
    b_rvalid_d = read_issued(arb_gnt_s[1], b_we);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CTRL_IDLE;
      cnt_q      <= {ADDR_BITS{1'b0}};
      clr_busy_q <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural RAM, a shadow memory
// and per-requester read scoreboards.
module tb_ram_access_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_start;
  logic          clr_busy;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] rdata;
  logic          ram_wr_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] env_mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  logic          m_ptr;
  int            m_clr_left;
  int            m_clr_cnt;
  logic          m_last_ga;

  ram_access_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .rdata        (rdata),
    .ram_wr_n     (ram_wr_n),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read, write takes priority over read.
  always @(posedge clk) begin
    if (!ram_wr_n) env_mem[ram_addr] <= ram_data_in;
    else           ram_data_out      <= env_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // One clock: predict and check the combinational port, then the registered outputs.
  task automatic step();
    logic          en, ga, gb, start_ok, erva, ervb, exp_wr_n;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    #1;
    start_ok = rst_n && (m_clr_left == 0) && clr_start;
    en       = rst_n && (m_clr_left == 0) && !clr_start;
    ga       = en && a_req && (!b_req || !m_ptr);
    gb       = en && b_req && (!a_req || m_ptr);
    exp_wr_n = 1'b1; exp_addr = '0; exp_din = '0;
    if (m_clr_left > 0) begin
      exp_wr_n = 1'b0;
      exp_addr = m_clr_cnt[AW-1:0];
      exp_mem[m_clr_cnt] = '0;
      m_clr_cnt++;
      m_clr_left--;
    end else if (ga) begin
      exp_wr_n = !a_we; exp_addr = a_addr; exp_din = a_wdata;
      if (a_we) exp_mem[a_addr] = a_wdata;
      else      qa.push_back(exp_mem[a_addr]);
    end else if (gb) begin
      exp_wr_n = !b_we; exp_addr = b_addr; exp_din = b_wdata;
      if (b_we) exp_mem[b_addr] = b_wdata;
      else      qb.push_back(exp_mem[b_addr]);
    end
    if (start_ok) begin
      m_clr_left = DEPTH;
      m_clr_cnt  = 0;
    end
    if (ga) m_ptr = 1'b1;
    if (gb) m_ptr = 1'b0;
    m_last_ga = ga;
    erva = ga && !a_we;
    ervb = gb && !b_we;
    chk("a_gnt", 32'(a_gnt), 32'(ga));
    chk("b_gnt", 32'(b_gnt), 32'(gb));
    chk("ram_wr_n", 32'(ram_wr_n), 32'(exp_wr_n));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    chk("ram_data_in", 32'(ram_data_in), 32'(exp_din));
    @(posedge clk);
    #1;
    chk("a_rvalid", 32'(a_rvalid), 32'(erva));
    chk("b_rvalid", 32'(b_rvalid), 32'(ervb));
    if (erva) chk("a_rdata", 32'(rdata), 32'(qa.pop_front()));
    if (ervb) chk("b_rdata", 32'(rdata), 32'(qb.pop_front()));
    chk("clr_busy", 32'(clr_busy), 32'(m_clr_left > 0));
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_gnt"}, 32'(a_gnt), 32'(0));
    chk({tag, "_b_gnt"}, 32'(b_gnt), 32'(0));
    chk({tag, "_ram_wr_n"}, 32'(ram_wr_n), 32'(1));
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    chk({tag, "_ram_data_in"}, 32'(ram_data_in), 32'(0));
    chk({tag, "_clr_busy"}, 32'(clr_busy), 32'(0));
    chk({tag, "_a_rvalid"}, 32'(a_rvalid), 32'(0));
    chk({tag, "_b_rvalid"}, 32'(b_rvalid), 32'(0));
  endtask

  task automatic model_reset();
    m_ptr = 1'b0; m_clr_left = 0; m_clr_cnt = 0; m_last_ga = 1'b0;
    qa.delete(); qb.delete();
  endtask

  initial begin
    int n;
    model_reset();
    rst_n = 1'b0; clr_start = 1'b0;
    // Requests raised during reset must not leak onto the RAM port.
    set_a(1'b1, 1'b1, 8'h05, 16'hAAAA);
    set_b(1'b1, 1'b0, 8'h06, 16'h5555);
    #3;
    check_reset_outputs("in_reset");
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset release
    for (int i = 0; i < 10; i++) step();

    // 2: A writes, B reads it back
    set_a(1'b1, 1'b1, 8'h05, 16'h1234); step();
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b1, 1'b0, 8'h05, 16'h0000); step();
    set_b(1'b0, 1'b0, 8'h00, 16'h0000); step();

    // Read-after-write at the same address in consecutive grants
    set_a(1'b1, 1'b1, 8'h0A, 16'h0077); step();
    set_a(1'b1, 1'b0, 8'h0A, 16'h0000); step();
    set_b(1'b1, 1'b1, 8'h06, 16'hC3C3); step();
    set_a(1'b0, 1'b0, 8'h00, 16'h0000); step();
    set_b(1'b0, 1'b0, 8'h00, 16'h0000); step();

    // 3: both read every cycle, grants must alternate
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 1'b0, 8'h05, 16'h0000);
      set_b(1'b1, 1'b0, 8'h06, 16'h0000);
      step();
    end
    // Contended write: A wins, B then withdraws and its request is dropped
    set_a(1'b1, 1'b1, 8'h30, 16'h1111);
    set_b(1'b1, 1'b1, 8'h31, 16'h2222); step();
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 3; i++) step();
    set_b(1'b1, 1'b0, 8'h31, 16'h0000); step();
    set_b(1'b0, 1'b0, 8'h00, 16'h0000); step();

    // 4: fill with 0xFFFF, sweep, confirm zero
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b1, 1'b1, AW'(i), 16'hFFFF); step();
    end
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    clr_start = 1'b1; step();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    clr_start = 1'b1; step();
    clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) step();
    for (int i = 0; i < DEPTH; i++) begin
      set_b(1'b1, 1'b0, AW'(i), 16'h0000); step();
    end
    set_b(1'b0, 1'b0, 8'h00, 16'h0000); step();

    // 5: A requests across a sweep and is served only after it ends
    set_a(1'b1, 1'b1, 8'h20, 16'hBEEF);
    clr_start = 1'b1; step();
    clr_start = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_last_ga && n < 400);
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b1, 1'b0, 8'h20, 16'h0000); step();
    set_b(1'b0, 1'b0, 8'h00, 16'h0000); step();

    // 6: reset mid-sweep leaves the upper part uncleared
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b1, 1'b1, AW'(i), 16'hFFFF); step();
    end
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    clr_start = 1'b1; step();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_sweep_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b1, 1'b0, AW'(i), 16'h0000); step();
    end
    set_a(1'b0, 1'b0, 8'h00, 16'h0000);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
